mdu_seq: RTL and testbench



---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_seq_if.sv | 28 ++
 rtl/cla_32.sv | 56 +++++
 rtl/mdu_seq.sv | 185 ++++++++++++++++++
 tb/tb_mdu_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package mdu_pkg;

    localparam int CALC_CYCLES = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_CALC,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_seq_if.sv
// Pipeline <-> MDU bundle: op launch, MTHI/MTLO writes, HI/LO and stall status.
interface mdu_seq_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, cancel, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: 4-bit groups with lookahead across groups.
module cla_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        g_out,
    output logic        p_out
);

    logic [31:0] g, p, c;
    logic [7:0]  gg, gp, gc;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (&p[4*k+1 +: 3] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    always_comb begin
        gc    = '0;
        gc[0] = cin;
        for (int k = 0; k < 7; k++)
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (&p[4*k +: 3] & gc[k]);
        end
    end

    assign sum = p ^ c;

    // Word-level generate is independent of cin so the caller can form carry-out.
    always_comb begin
        g_out = 1'b0;
        for (int k = 0; k < 8; k++)
            g_out = gg[k] | (gp[k] & g_out);
    end

    assign p_out = &gp;

endmodule

// File: rtl/mdu_seq.sv
// MIPS HI/LO multiply/divide sequencer: fixed 37-cycle schedule over one shared
// 32-bit adder (operand negate, shift-add, restoring subtract, sign fix-up).
module mdu_seq #(
    parameter int CALC_CYCLES = mdu_pkg::CALC_CYCLES
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);

    import mdu_pkg::*;

    mdu_state_e  state, state_nxt;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] hi_acc, lo_acc;
    logic [31:0] hi_r, lo_r;
    logic        a_sgn, b_sgn, b_zero, fc;
    logic        busy_w, done_w, accept;

    logic [31:0] add_x, add_y, add_sum, rem_sh;
    logic        add_inv, add_cin, add_g, add_p, add_co;
    logic        is_div, sgn, neg_lo, neg_hi, take;

    assign is_div = op_r[1];
    assign sgn    = ~op_r[0];
    assign neg_lo = sgn & (a_sgn ^ b_sgn);
    assign neg_hi = is_div ? (sgn & a_sgn) : neg_lo;
    assign rem_sh = {hi_acc[30:0], lo_acc[31]};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_w    = 1'b0;
        done_w    = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done_w    = (state == S_DONE);
                state_nxt = S_IDLE;
                if (bus.start && !bus.cancel) begin
                    accept    = 1'b1;
                    state_nxt = S_NEG_A;
                end
            end
            S_NEG_A:  state_nxt = S_NEG_B;
            S_NEG_B:  state_nxt = S_CALC;
            S_CALC:   if (cnt == 5'(CALC_CYCLES - 1)) state_nxt = S_FIX_LO;
            S_FIX_LO: state_nxt = S_FIX_HI;
            S_FIX_HI: state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE && state != S_DONE) begin
            busy_w = 1'b1;
            if (bus.cancel) state_nxt = S_IDLE;
        end
    end

    // Single adder: s = x + (y ^ {32{inv}}) + cin; every step picks its operands here.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_inv = 1'b0;
        add_cin = 1'b0;
        case (state)
            S_NEG_A: begin
                add_y   = a_r;
                add_inv = sgn & a_sgn;
                add_cin = sgn & a_sgn;
            end
            S_NEG_B: begin
                add_y   = b_r;
                add_inv = sgn & b_sgn;
                add_cin = sgn & b_sgn;
            end
            S_CALC: begin
                if (is_div) begin
                    add_x   = rem_sh;
                    add_y   = b_r;
                    add_inv = 1'b1;
                    add_cin = 1'b1;
                end else begin
                    add_x = hi_acc;
                    add_y = lo_acc[0] ? a_r : 32'd0;
                end
            end
            S_FIX_LO: begin
                add_y   = lo_acc;
                add_inv = neg_lo;
                add_cin = neg_lo;
            end
            S_FIX_HI: begin
                add_y   = hi_acc;
                add_inv = neg_hi;
                add_cin = is_div ? neg_hi : fc;
            end
            default: ;
        endcase
    end

    cla_32 u_cla (
        .x     (add_x),
        .y     (add_y ^ {32{add_inv}}),
        .cin   (add_cin),
        .sum   (add_sum),
        .g_out (add_g),
        .p_out (add_p)
    );

    assign add_co = add_g | (add_p & add_cin);
    assign take   = hi_acc[31] | add_co;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            hi_acc <= '0;
            lo_acc <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            a_sgn  <= 1'b0;
            b_sgn  <= 1'b0;
            b_zero <= 1'b0;
            fc     <= 1'b0;
        end else begin
            if (!busy_w && bus.hi_we) hi_r <= bus.wdata;
            if (!busy_w && bus.lo_we) lo_r <= bus.wdata;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_r   <= bus.op;
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        a_sgn  <= bus.a[31];
                        b_sgn  <= bus.b[31];
                        b_zero <= (bus.b == 32'd0);
                        cnt    <= '0;
                    end
                end
                S_NEG_A: a_r <= add_sum;
                S_NEG_B: begin
                    b_r    <= add_sum;
                    hi_acc <= '0;
                    lo_acc <= is_div ? a_r : add_sum;
                end
                S_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        hi_acc <= take ? add_sum : rem_sh;
                        lo_acc <= {lo_acc[30:0], take};
                    end else begin
                        hi_acc <= {add_co, add_sum[31:1]};
                        lo_acc <= {add_sum[0], lo_acc[31:1]};
                    end
                end
                S_FIX_LO: begin
                    lo_acc <= add_sum;
                    fc     <= add_co;
                end
                S_FIX_HI: begin
                    // Divide by zero leaves |a| in R, so HI fixes up to the original a.
                    if (state_nxt == S_DONE) begin
                        hi_r <= add_sum;
                        lo_r <= (is_div && b_zero) ? 32'hFFFF_FFFF : lo_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_w;
    assign bus.done        = done_w;
    assign bus.div_by_zero = done_w & is_div & b_zero;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: schedule timing, signed/unsigned results, cancel, reset.
module tb_mdu_seq;

    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mdu_seq_if bus ();

    mdu_seq #(.CALC_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    // Walks cycles from c0 until done; records done cycle and busy behaviour.
    task automatic wait_done(input int c0, output int dcyc, output int bcnt, output logic bad);
        dcyc = -1; bcnt = 0; bad = 1'b0;
        for (int c = c0; c <= 80; c++) begin
            if (bus.done) begin
                dcyc = c;
                bad  = bad | bus.busy;
                break;
            end
            if (bus.busy) bcnt++;
            else          bad = 1'b1;
            step(1);
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cancel = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        rst_n = 1'b0;
        step(2);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.done); end
        n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset dbz: got %b want 0", bus.div_by_zero); end
        n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset hi: got %h want 0", bus.hi); end
        n_tests++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset lo: got %h want 0", bus.lo); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_multu();
        int d, bc; logic bad;
        kick(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, d, bc, bad);
        n_tests++; if (d !== 37) begin n_fail++; $display("FAIL multu done cycle: got %0d want 37", d); end
        n_tests++; if (bc !== 36 || bad !== 1'b0) begin n_fail++; $display("FAIL multu busy window: got %0d cycles bad=%b want 36 bad=0", bc, bad); end
        n_tests++; if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu hi: got %h want fffffffe", bus.hi); end
        n_tests++; if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu lo: got %h want 00000001", bus.lo); end
        n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL multu dbz: got %b want 0", bus.div_by_zero); end
        step(1);
        n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu after done: done=%b busy=%b want 0 0", bus.done, bus.busy); end
    endtask

    task automatic test_mult();
        int d, bc; logic bad;
        kick(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(1, d, bc, bad);
        n_tests++; if (d !== 37) begin n_fail++; $display("FAIL mult_neg done cycle: got %0d want 37", d); end
        n_tests++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg hi: got %h want ffffffff", bus.hi); end
        n_tests++; if (bus.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg lo: got %h want ffffffeb", bus.lo); end
        step(1);
        kick(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(1, d, bc, bad);
        n_tests++; if (bus.hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min hi: got %h want 40000000", bus.hi); end
        n_tests++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL mult_min lo: got %h want 00000000", bus.lo); end
        step(1);
    endtask

    task automatic test_div();
        int d, bc; logic bad;
        kick(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, d, bc, bad);
        n_tests++; if (d !== 37) begin n_fail++; $display("FAIL div_neg done cycle: got %0d want 37", d); end
        n_tests++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg lo: got %h want fffffffd", bus.lo); end
        n_tests++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg hi: got %h want ffffffff", bus.hi); end
        n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div_neg dbz: got %b want 0", bus.div_by_zero); end
        step(1);
        kick(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, d, bc, bad);
        n_tests++; if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf lo: got %h want 80000000", bus.lo); end
        n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf hi: got %h want 00000000", bus.hi); end
        step(1);
    endtask

    task automatic test_div_zero();
        int d, bc; logic bad;
        kick(OP_DIVU, 32'd5, 32'd0);
        wait_done(1, d, bc, bad);
        n_tests++; if (d !== 37) begin n_fail++; $display("FAIL divu_zero done cycle: got %0d want 37", d); end
        n_tests++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero lo: got %h want ffffffff", bus.lo); end
        n_tests++; if (bus.hi !== 32'd5) begin n_fail++; $display("FAIL divu_zero hi: got %h want 00000005", bus.hi); end
        n_tests++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL divu_zero dbz: got %b want 1", bus.div_by_zero); end
        step(1);
        n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL divu_zero dbz after: got %b want 0", bus.div_by_zero); end
        kick(OP_DIV, 32'hFFFF_FFF8, 32'd0);
        wait_done(1, d, bc, bad);
        n_tests++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_zero lo: got %h want ffffffff", bus.lo); end
        n_tests++; if (bus.hi !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL div_zero hi: got %h want fffffff8", bus.hi); end
        n_tests++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div_zero dbz: got %b want 1", bus.div_by_zero); end
        step(1);
    endtask

    task automatic test_cancel();
        logic seen;
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_1234;
        step(1);
        bus.lo_we = 1'b0; bus.hi_we = 1'b1; bus.wdata = 32'h0000_ABCD;
        step(1);
        bus.hi_we = 1'b0;
        n_tests++; if (bus.lo !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo: got %h want 00001234", bus.lo); end
        kick(OP_MULT, 32'd5, 32'd6);
        step(9);
        bus.cancel = 1'b1;
        step(1);
        bus.cancel = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel busy: got %b want 0", bus.busy); end
        seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            seen = seen | bus.done;
            step(1);
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel done seen: got %b want 0", seen); end
        n_tests++; if (bus.lo !== 32'h0000_1234) begin n_fail++; $display("FAIL cancel lo: got %h want 00001234", bus.lo); end
        n_tests++; if (bus.hi !== 32'h0000_ABCD) begin n_fail++; $display("FAIL cancel hi: got %h want 0000abcd", bus.hi); end
        bus.cancel = 1'b1;
        kick(OP_MULTU, 32'd2, 32'd3);
        bus.cancel = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_start busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int d, bc; logic bad;
        kick(OP_DIVU, 32'd100, 32'd7);
        wait_done(1, d, bc, bad);
        n_tests++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu lo: got %h want 0000000e", bus.lo); end
        n_tests++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu hi: got %h want 00000002", bus.hi); end
        kick(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(1, d, bc, bad);
        n_tests++; if (d !== 37 || bc !== 36) begin n_fail++; $display("FAIL b2b timing: got done %0d busy %0d want 37 36", d, bc); end
        n_tests++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL b2b result: got %h_%h want ffffffff_ffffffeb", bus.hi, bus.lo); end
        step(1);
    endtask

    task automatic test_reset_mid();
        kick(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(9);
        rst_n = 1'b0;
        step(1);
        n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midreset flags: got busy=%b done=%b dbz=%b want 0 0 0", bus.busy, bus.done, bus.div_by_zero); end
        n_tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_fail++; $display("FAIL midreset hilo: got %h_%h want 0_0", bus.hi, bus.lo); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_start_busy();
        int d, bc; logic bad;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        kick(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
        bus.hi_we = 1'b0;
        n_tests++; if (bus.hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_with_start hi: got %h want deadbeef", bus.hi); end
        step(3);
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_5555;
        kick(OP_DIVU, 32'd1, 32'd1);
        bus.hi_we = 1'b0;
        n_tests++; if (bus.hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL busy write hi: got %h want deadbeef", bus.hi); end
        wait_done(5, d, bc, bad);
        n_tests++; if (d !== 37) begin n_fail++; $display("FAIL start_busy done cycle: got %0d want 37", d); end
        n_tests++; if (bus.hi !== 32'd3 || bus.lo !== 32'd0) begin n_fail++; $display("FAIL start_busy result: got %h_%h want 00000003_00000000", bus.hi, bus.lo); end
        step(1);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        test_start_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
